subtrator_serial_ctrl: RTL and testbench
========================================

# subtrator_serial_ctrl

Bit-serial controller that computes an unsigned WIDTH-bit difference `a - b` using a single full-subtractor cell, one bit per clock, LSB first. It latches both operands on a start request, runs the borrow through a flop between bit steps, and presents the full difference and final borrow with a one-cycle completion pulse. It sits between operand producers and any consumer that needs subtraction results but cannot afford a WIDTH-bit parallel subtractor.

## Interface

- `WIDTH`, 8, operand and result width in bits; legal range 2..32.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `start` input 1 — request; sampled only in IDLE.
- `a` input WIDTH — minuend; captured on the accepting edge only.
- `b` input WIDTH — subtrahend; captured on the accepting edge only.
- `busy` output 1 — high while bits are being processed (RUN).
- `done` output 1 — one-cycle pulse, high in DONE.
- `diff` output WIDTH — registered result `(a - b) mod 2^WIDTH`.
- `borrow_out` output 1 — registered final borrow; 1 iff `a < b` (unsigned).

## Operation

- One full-subtractor cell, inside this block: `s = ai ^ bi ^ bin`, `bout = (~ai & bi) | (~(ai ^ bi) & bin)`.
- Internal state: operand shift registers `sa` and `sb` (WIDTH each), result shift register `sr` (WIDTH), borrow flop `bf`, bit counter `cnt` (`$clog2(WIDTH)` bits), and a 2-bit FSM.
- IDLE:
  - `start=1` → load `sa<=a`, `sb<=b`, `bf<=0`, `cnt<=0`; go to RUN.
  - `start=0` → stay in IDLE.
- RUN, each edge:
  - Feed `sa[0]`, `sb[0]`, `bf` to the cell.
  - Shift `s` into `sr` from the MSB side, so after WIDTH steps bit 0 is at `sr[0]`.
  - Shift `sa` and `sb` right by 1.
  - `bf<=bout`, `cnt<=cnt+1`.
  - On the edge where `cnt==WIDTH-1`: `diff<=` the final shifted `sr` value (including this step's `s`), `borrow_out<=bout`; go to DONE.
- DONE: `done=1` for exactly one cycle; unconditionally return to IDLE on the next edge.
- `start` is ignored in RUN and DONE. It is not queued: a request must be held or reissued until the block is in IDLE.
- `diff` and `borrow_out` change only at completion. They hold their values through IDLE and through the next operation's RUN until that operation completes.
- `busy = (state==RUN)`, `done = (state==DONE)`; both are decoded directly from state registers, with no combinational path from inputs.
- The unused fourth FSM encoding recovers to IDLE on the next edge.

## Timing

- Reset (`rst=1` at an edge): state IDLE, `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `cnt=0`, `bf=0`, shift registers 0.
- `rst` overrides everything, including `start` sampled on the same edge.
- Reset during RUN or DONE abandons the operation: no `done` pulse, and `diff`/`borrow_out` go to 0.
- Latency, with `start` accepted at edge E0:
  - `busy` is high from after E0 to after E_WIDTH (WIDTH cycles).
  - `diff`, `borrow_out` and `done` become valid after E_WIDTH.
  - `done` falls after E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next acceptance is E_WIDTH+2, with `start` high in the cycle after `done`.
- `start` held high continuously gives back-to-back operations every WIDTH+2 cycles; new operands are sampled at each acceptance.
- Operand inputs may change freely after E0 without affecting the result in flight.

## Test plan

- Reset then idle: `rst` high 2 cycles with `start=1` → `busy=0`, `done=0`, `diff=0`, `borrow_out=0`; no operation starts.
- Basic difference, WIDTH=8: `a=100`, `b=37`, `start` for one cycle → `busy` high exactly 8 cycles, `done` pulses once, `diff=63`, `borrow_out=0`.
- Borrow cases:
  - `a=5`, `b=9` → `diff=252`, `borrow_out=1`.
  - `a=0`, `b=1` → `diff=255`, `borrow_out=1`.
  - `a=255`, `b=255` → `diff=0`, `borrow_out=0`.
- Exhaustive cell check, WIDTH=2: all 16 `(a,b)` pairs → `diff==(a-b)&3` and `borrow_out==(a<b)` for every pair. This exercises all 8 cell input combinations of the full subtractor.
- Ignored start: during RUN of `20-3`, pulse `start` with `a=1`, `b=2`, and also pulse it during DONE → result `17`/`0`, a single `done` pulse, and no second operation.
- Reset mid-operation: assert `rst` at the 4th RUN cycle → no `done` pulse, outputs 0. A following `start` with `a=10`, `b=4` → `diff=6` after the full WIDTH+1 latency.

Source files
------------

// File: rtl/subtrator_serial_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor: the producer drives
// the request and operands, and the subtractor returns status and result.
interface subtrator_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, one bit per clock,
// with the borrow carried between bit steps in a flop.
module subtrator_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  subtrator_serial_ctrl_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bf_q, bf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             cell_s;
  logic             cell_bout;
  logic [WIDTH-1:0] sr_shift;

  always_comb begin
    cell_s    = sa_q[0] ^ sb_q[0] ^ bf_q;
    cell_bout = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
    // New bit enters at the MSB so the first (LSB) bit ends up at sr[0].
    sr_shift  = {cell_s, sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    bf_d     = bf_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d  = sr_shift;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bf_d  = cell_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d   = sr_shift;
          borrow_d = cell_bout;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      bf_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      bf_q     <= bf_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Directed bench for the bit-serial subtractor: an 8-bit instance for the main scenarios
// and a 2-bit instance swept over every operand pair.
module tb_subtrator_serial_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  subtrator_serial_ctrl_if #(.WIDTH(8)) bus8 ();
  subtrator_serial_ctrl_if #(.WIDTH(2)) bus2 ();

  subtrator_serial_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  subtrator_serial_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one 8-bit operation and follows it until the cycle after done.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                        output int busy_cnt, output int done_cnt, output int lat,
                        output logic [7:0] d, output logic bo);
    bus8.a = av;
    bus8.b = bv;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    lat = -1;
    d = 'x;
    bo = 1'bx;
    for (int i = 0; i < 30; i++) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin
        if (done_cnt == 0) lat = i + 1;
        done_cnt++;
        d = bus8.diff;
        bo = bus8.borrow_out;
      end else if (done_cnt > 0) begin
        break;
      end
      tick();
    end
  endtask

  task automatic do_op2(input logic [1:0] av, input logic [1:0] bv,
                        output int busy_cnt, output int done_cnt,
                        output logic [1:0] d, output logic bo);
    bus2.a = av;
    bus2.b = bv;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    d = 'x;
    bo = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (bus2.busy) busy_cnt++;
      if (bus2.done) begin
        done_cnt++;
        d = bus2.diff;
        bo = bus2.borrow_out;
      end else if (done_cnt > 0) begin
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'd100; bus8.b = 8'd37;
    bus2.start = 1'b1; bus2.a = 2'd1;   bus2.b = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow_out} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset8 cyc%0d: busy=%b done=%b diff=%0d borrow=%b, expected all 0",
                 i, bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
      end
      n_cmp++;
      if ({bus2.busy, bus2.done, bus2.diff, bus2.borrow_out} !== 5'd0) begin
        n_fail++;
        $display("FAIL reset2 cyc%0d: busy=%b done=%b diff=%0d borrow=%b, expected all 0",
                 i, bus2.busy, bus2.done, bus2.diff, bus2.borrow_out);
      end
    end
    bus8.start = 1'b0;
    bus2.start = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_start: busy=%b done=%b, expected 0 0", bus8.busy, bus8.done);
    end
    $display("reset: checked idle outputs after reset with start held");
  endtask

  task automatic test_basic();
    int bc, dc, lat; logic [7:0] d; logic bo;
    do_op8(8'd100, 8'd37, bc, dc, lat, d, bo);
    n_cmp++;
    if (d !== 8'd63 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: diff=%0d borrow=%b, expected 63 0", d, bo);
    end
    n_cmp++;
    if (bc !== 8 || dc !== 1 || lat !== 9) begin
      n_fail++;
      $display("FAIL basic_timing: busy=%0d done=%0d lat=%0d, expected 8 1 9", bc, dc, lat);
    end
    $display("basic: 100-37 -> diff=%0d borrow=%b busy=%0d", d, bo, bc);
  endtask

  task automatic test_borrow();
    logic [7:0] va [3] = '{8'd5, 8'd0, 8'd255};
    logic [7:0] vb [3] = '{8'd9, 8'd1, 8'd255};
    logic [7:0] ed [3] = '{8'd252, 8'd255, 8'd0};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      int bc, dc, lat; logic [7:0] d; logic bo;
      do_op8(va[k], vb[k], bc, dc, lat, d, bo);
      n_cmp++;
      if (d !== ed[k] || bo !== eb[k] || dc !== 1) begin
        n_fail++;
        $display("FAIL borrow %0d-%0d: diff=%0d borrow=%b done=%0d, expected %0d %b 1",
                 va[k], vb[k], d, bo, dc, ed[k], eb[k]);
      end
      $display("borrow: %0d-%0d -> diff=%0d borrow=%b", va[k], vb[k], d, bo);
    end
  endtask

  task automatic test_exhaustive2();
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        int bc, dc; logic [1:0] d; logic bo;
        logic [1:0] ed; logic eb;
        ed = 2'((ia - ib) & 3);
        eb = (ia < ib);
        do_op2(2'(ia), 2'(ib), bc, dc, d, bo);
        n_cmp++;
        if (d !== ed || bo !== eb || bc !== 2 || dc !== 1) begin
          n_fail++;
          $display("FAIL w2 %0d-%0d: diff=%0d borrow=%b busy=%0d done=%0d, expected %0d %b 2 1",
                   ia, ib, d, bo, bc, dc, ed, eb);
        end
        $display("w2: %0d-%0d -> diff=%0d borrow=%b", ia, ib, d, bo);
      end
    end
  endtask

  task automatic test_ignored_start();
    int bc = 0, dc = 0, extra = 0;
    logic [7:0] d = 'x; logic bo = 1'bx;
    bus8.a = 8'd20; bus8.b = 8'd3; bus8.start = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (bus8.busy) bc++;
      if (bus8.done) begin
        dc++; d = bus8.diff; bo = bus8.borrow_out;
      end
      if (i == 3) begin
        bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2;
      end else if (bus8.done) begin
        bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      if (i < 3) bus8.start = 1'b0;
      tick();
    end
    bus8.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.busy || bus8.done) extra++;
      tick();
    end
    n_cmp++;
    if (d !== 8'd17 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_result: diff=%0d borrow=%b, expected 17 0", d, bo);
    end
    n_cmp++;
    if (dc !== 1 || bc !== 8 || extra !== 0) begin
      n_fail++;
      $display("FAIL ignored_single_op: done=%0d busy=%0d extra=%0d, expected 1 8 0", dc, bc, extra);
    end
    $display("ignored_start: 20-3 -> diff=%0d done_pulses=%0d", d, dc);
  endtask

  task automatic test_reset_mid();
    int bc, dc, lat, seen = 0; logic [7:0] d; logic bo;
    bus8.a = 8'd200; bus8.b = 8'd50; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (bus8.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_running: busy=%b, expected 1", bus8.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done || bus8.busy) seen++;
      if (i == 0) begin
        n_cmp++;
        if (bus8.diff !== 8'd0 || bus8.borrow_out !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs: diff=%0d borrow=%b, expected 0 0",
                   bus8.diff, bus8.borrow_out);
        end
      end
      tick();
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: active cycles=%0d, expected 0", seen);
    end
    do_op8(8'd10, 8'd4, bc, dc, lat, d, bo);
    n_cmp++;
    if (d !== 8'd6 || bo !== 1'b0 || lat !== 9 || dc !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_next: diff=%0d borrow=%b lat=%0d done=%0d, expected 6 0 9 1",
               d, bo, lat, dc);
    end
    $display("reset_mid: abandoned 200-50, then 10-4 -> diff=%0d lat=%0d", d, lat);
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int done_at [2] = '{-1, -1};
    logic [7:0] dv [2];
    logic       bv [2];
    bus8.a = 8'd50; bus8.b = 8'd8; bus8.start = 1'b1;
    tick();
    for (int c = 0; c < 30; c++) begin
      if (bus8.done) begin
        if (k < 2) begin
          done_at[k] = c; dv[k] = bus8.diff; bv[k] = bus8.borrow_out;
        end
        k++;
        if (k == 1) begin
          bus8.a = 8'd7; bus8.b = 8'd9;
        end
        if (k == 2) bus8.start = 1'b0;
      end
      tick();
    end
    bus8.start = 1'b0;
    n_cmp++;
    if (k !== 2 || done_at[0] !== 8 || done_at[1] !== 18) begin
      n_fail++;
      $display("FAIL b2b_timing: pulses=%0d at %0d,%0d, expected 2 at 8,18",
               k, done_at[0], done_at[1]);
    end
    n_cmp++;
    if (dv[0] !== 8'd42 || bv[0] !== 1'b0 || dv[1] !== 8'd254 || bv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_results: %0d/%b %0d/%b, expected 42/0 254/1", dv[0], bv[0], dv[1], bv[1]);
    end
    $display("back_to_back: 50-8=%0d then 7-9=%0d, done spacing %0d",
             dv[0], dv[1], done_at[1] - done_at[0]);
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_exhaustive2();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
